// File: rtl/clock_step_ctrl_if.sv
// clock_step_ctrl_if: control/status bundle between the CPU clock controller and its master
interface clock_step_ctrl_if #(parameter int CNT_W = 32);
  logic [1:0] mode;
  logic start;
  logic stop;
  logic halt_req;
  logic [CNT_W-1:0] div;
  logic div_load;
  logic [7:0] burst_len;
  logic step_btn;
  logic cpu_ce;
  logic [1:0] state;
  logic halted;
  logic [15:0] ce_count;
  modport master(output mode, start, stop, halt_req, div, div_load, burst_len, step_btn,
                 input cpu_ce, state, halted, ce_count);
  modport slave(input mode, start, stop, halt_req, div, div_load, burst_len, step_btn,
                output cpu_ce, state, halted, ce_count);
endinterface

// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: halt/run/step/burst CPU clock-enable generator; clkin, async clr_n, bus = controls in, cpu_ce/state/halted/ce_count out
module clock_step_ctrl #(
  parameter int CNT_W = 32,
  parameter int DEFAULT_DIV = 25000000
) (
  input logic clkin,
  input logic clr_n,
  clock_step_ctrl_if.slave bus
);
  localparam logic [1:0] HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, BURST = 2'd3;
  logic [CNT_W-1:0] cnt, div_r;
  logic [7:0] burst_rem;
  logic s1, s2, s3;
  logic active, kill, tick, go, last;
  logic [1:0] nxt;
  always_comb begin
    active = bus.state == RUN || bus.state == BURST;
    kill = bus.halt_req || bus.stop;
    tick = active && cnt == div_r && !bus.div_load;
    go = bus.state == HALT && bus.start && !kill;
    last = bus.state == BURST && tick && burst_rem == 8'd1;
    nxt = bus.state == HALT ? ((go && !(bus.mode == BURST && bus.burst_len == 8'd0)) ? bus.mode : HALT)
        : (kill || last) ? HALT : bus.state;
  end
  always_ff @(posedge clkin or negedge clr_n)
    if (!clr_n) begin
      bus.state <= HALT;
      bus.halted <= 1'b1;
      bus.cpu_ce <= 1'b0;
      bus.ce_count <= '0;
      cnt <= '0;
      div_r <= CNT_W'(DEFAULT_DIV);
      burst_rem <= '0;
      {s1, s2, s3} <= '0;
    end else begin
      bus.state <= nxt;
      bus.halted <= nxt == HALT;
      bus.cpu_ce <= (bus.state != HALT && kill) ? 1'b0 : bus.state == STEP ? s2 & ~s3 : tick;
      bus.ce_count <= bus.ce_count + {15'd0, bus.cpu_ce};
      cnt <= (bus.div_load || tick || !active || kill) ? '0 : cnt + CNT_W'(1);
      div_r <= bus.div_load ? bus.div : div_r;
      burst_rem <= go ? bus.burst_len : (bus.state == BURST && tick) ? burst_rem - 8'd1 : burst_rem;
      {s1, s2, s3} <= {bus.step_btn, s1, s2};
    end
endmodule

// File: tb/tb_clock_step_ctrl.sv
// tb_clock_step_ctrl: directed self-checking bench for clock_step_ctrl
module tb_clock_step_ctrl;
  logic clkin = 1'b0;
  logic clr_n = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int n, first;
  clock_step_ctrl_if #(.CNT_W(32)) b();
  clock_step_ctrl #(.CNT_W(32), .DEFAULT_DIV(25000000)) dut(.clkin(clkin), .clr_n(clr_n), .bus(b.slave));
  always #5 clkin = ~clkin;
  task automatic cyc(input int k = 1);
    repeat (k) @(posedge clkin);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [31:0] d);
    b.div = d;
    b.div_load = 1'b1;
    cyc();
    b.div_load = 1'b0;
  endtask
  task automatic go(input logic [1:0] m);
    b.mode = m;
    b.start = 1'b1;
    cyc();
    b.start = 1'b0;
  endtask
  task automatic halt();
    b.stop = 1'b1;
    cyc();
    b.stop = 1'b0;
  endtask
  initial begin
    b.mode = 2'd0; b.start = 0; b.stop = 0; b.halt_req = 0; b.div = '0;
    b.div_load = 0; b.burst_len = 8'd0; b.step_btn = 0;
    cyc(2);
    chk("rst_state", b.state, 0);
    chk("rst_halted", b.halted, 1);
    chk("rst_ce", b.cpu_ce, 0);
    chk("rst_count", b.ce_count, 0);
    clr_n = 1'b1;
    cyc();
    load(3);
    go(2'd1);
    chk("run_state", b.state, 1);
    cyc(3);
    chk("run_pre", b.cpu_ce, 0);
    cyc();
    chk("run_first", b.cpu_ce, 1);
    for (int p = 0; p < 4; p++) begin
      cyc();
      chk("run_gap", b.cpu_ce, 0);
      cyc(3);
      chk("run_pulse", b.cpu_ce, 1);
    end
    halt();
    chk("stop_halted", b.halted, 1);
    chk("stop_ce", b.cpu_ce, 0);
    chk("run_count5", b.ce_count, 5);
    cyc(10);
    chk("stop_quiet", b.ce_count, 5);
    load(0);
    b.burst_len = 8'd3;
    go(2'd3);
    chk("burst_state", b.state, 3);
    chk("burst_pre", b.cpu_ce, 0);
    cyc();
    chk("burst_p1", b.cpu_ce, 1);
    cyc();
    chk("burst_p2", b.cpu_ce, 1);
    cyc();
    chk("burst_p3", b.cpu_ce, 1);
    chk("burst_end", b.state, 0);
    cyc();
    chk("burst_after", b.cpu_ce, 0);
    chk("burst_count", b.ce_count, 8);
    b.burst_len = 8'd0;
    go(2'd3);
    chk("burst0_state", b.state, 0);
    cyc(5);
    chk("burst0_count", b.ce_count, 8);
    go(2'd2);
    chk("step_state", b.state, 2);
    b.step_btn = 1'b1;
    n = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (b.cpu_ce) begin n++; first = i; end
    end
    chk("step_hold_n", n, 1);
    chk("step_latency", first, 3);
    b.step_btn = 1'b0;
    cyc(5);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      b.step_btn = (i % 8) < 4;
      cyc();
      n += b.cpu_ce;
    end
    chk("step_two", n, 2);
    halt();
    load(100);
    go(2'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      b.step_btn = i < 5;
      cyc();
      n += b.cpu_ce;
    end
    chk("run_btn_ign", n, 0);
    halt();
    chk("count_11", b.ce_count, 11);
    load(2);
    go(2'd1);
    cyc(2);
    b.halt_req = 1'b1;
    cyc();
    chk("hreq_ce", b.cpu_ce, 0);
    chk("hreq_state", b.state, 0);
    go(2'd1);
    chk("hreq_blocks", b.state, 0);
    b.halt_req = 1'b0;
    load(0);
    go(2'd1);
    for (int i = 0; i < 70000 && b.ce_count != 16'hffff; i++) cyc();
    chk("wrap_ffff", b.ce_count, 16'hffff);
    cyc();
    chk("wrap_zero", b.ce_count, 0);
    chk("mid_pulse", b.cpu_ce, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_ce", b.cpu_ce, 0);
    chk("arst_state", b.state, 0);
    chk("arst_count", b.ce_count, 0);
    cyc();
    clr_n = 1'b1;
    go(2'd1);
    cyc(30);
    chk("default_div", b.ce_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_step_ctrl.md
# clock_step_ctrl

Execution-clock controller for the microprocessor core. It owns the programmable prescaler that paces the CPU and issues single-cycle `cpu_ce` clock-enable pulses to the datapath. It supports four modes: halted, free-run at a programmable rate, single-step from a push-button, and a counted burst. It sits between the board clock and every CPU register enable, replacing the toggled divided clock with an enable in the `clkin` domain.

## Interface
- `CNT_W`, 32: prescaler counter and divisor width.
- `DEFAULT_DIV`, 25000000: divisor loaded at reset.
- `clkin` in 1: system clock; all logic is on the rising edge.
- `clr_n` in 1: reset; asynchronous assert, active-low.
- `mode` in 2: 00 halt, 01 run, 10 step, 11 burst. Sampled only when `start` is accepted.
- `start` in 1: one-cycle pulse; leaves HALT into the mode selected by `mode`.
- `stop` in 1: one-cycle pulse; returns to HALT.
- `halt_req` in 1: level from the CPU (HLT instruction); forces HALT.
- `div` in CNT_W: prescaler terminal count; the tick period is `div`+1 cycles.
- `div_load` in 1: latches `div` into `div_r`.
- `burst_len` in 8: number of pulses in burst mode.
- `step_btn` in 1: asynchronous push-button, already debounced externally.
- `cpu_ce` out 1: registered single-cycle clock-enable to the CPU.
- `state` out 2: 0 HALT, 1 RUN, 2 STEP, 3 BURST.
- `halted` out 1: high when `state` is HALT.
- `ce_count` out 16: total `cpu_ce` pulses issued; wraps.

## Operation
- Reset values:
  - `state`=HALT, `halted`=1, `cpu_ce`=0, `ce_count`=0.
  - `cnt`=0, `div_r`=DEFAULT_DIV, `burst_rem`=0.
  - Synchronizer flops = 0.
- FSM transitions from HALT:
  - On `start`, go to RUN if `mode`=01 or STEP if `mode`=10.
  - If `mode`=11, go to BURST with `burst_rem`←`burst_len`. If `burst_len`=0, stay in HALT.
  - If `mode`=00, stay in HALT.
- FSM transitions from RUN, STEP and BURST:
  - `halt_req` or `stop` returns to HALT.
  - BURST also returns to HALT on the edge that issues its last pulse.
- `start` is ignored outside HALT. `mode` changes outside HALT have no effect.
- Priority on the same edge: `clr_n` > `halt_req` > `stop` > `start`.
- Prescaler:
  - Counts only in RUN and BURST; held at 0 in HALT and STEP. `cnt` is cleared on every entry to RUN or BURST.
  - tick = (`cnt`==`div_r`). On a tick, `cnt`←0; otherwise `cnt`←`cnt`+1.
  - `div`=0 gives a tick every cycle.
- `div_load`:
  - Sets `div_r`←`div` and `cnt`←0 on the same edge, in any state. That edge issues no tick.
  - `div_load` coinciding with a terminal count suppresses that tick.
- RUN: `cpu_ce`←tick.
- STEP:
  - `step_btn` passes through a 2-flop synchronizer (s1, s2) plus a delay flop s3.
  - `cpu_ce`←s2 & ~s3. A button held high gives exactly one pulse.
  - A button edge seen while not in STEP is discarded.
- BURST:
  - `cpu_ce`←tick, and `burst_rem` decrements on each tick.
  - The tick with `burst_rem`=1 issues a pulse and moves to HALT on the same edge.
- Any edge on which `halt_req` or `stop` is accepted drives `cpu_ce`←0, even if a tick or step edge coincides.
- `ce_count` increments on each cycle where `cpu_ce`=1 and wraps 0xFFFF→0x0000.
- `clr_n` low at any time immediately forces all reset values, including `cpu_ce`=0 mid-pulse.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- RUN latency:
  - `start` sampled at edge 0 puts `state`=RUN after edge 0.
  - The first `cpu_ce` is high for the cycle after edge `div_r`+1.
  - Subsequent pulses come every `div_r`+1 cycles.
- STEP latency: when `step_btn` rises before edge k, `cpu_ce` is high for the one cycle after edge k+2.
- HALT response: a `halt_req` or `stop` sampled at edge n gives `state`=HALT and `cpu_ce`=0 after edge n.
- `cpu_ce` is never high for more than one cycle, except in RUN/BURST with `div_r`=0.

## Test plan
- Reset, then `div`=3 with `div_load`, `mode`=01, `start` → after 4 cycles the first `cpu_ce`; then pulses every 4 cycles; `ce_count`=5 after 5 pulses; `stop` → `halted`=1, no further pulses.
- `mode`=11, `burst_len`=3, `div`=0, `start` → `cpu_ce` high for exactly 3 consecutive cycles, then `state`=0. `burst_len`=0 with `start` → stays in HALT with zero pulses.
- `mode`=10: `step_btn` held high for 20 cycles → exactly one `cpu_ce`, 3 edges after the rise. Two separated presses → 2 pulses. A press while in RUN is ignored.
- RUN with `div`=2: assert `halt_req` on the terminal-count cycle → no pulse on that edge, `state`=HALT; a later `start` with `halt_req` still high stays in HALT.
- Preload `ce_count` near the limit by running with `div`=0 for 65536 pulses → `ce_count` wraps to 0. Drop `clr_n` mid-pulse → `cpu_ce` drops asynchronously and `div_r` returns to DEFAULT_DIV.
